// File: rtl/caliptra_imem_stream_loader.sv
// Byte-stream to IMEM word loader: packs bytes little-endian into DATA_W-bit words,
// writes them from address 0 upward and releases the core reset once the image is in.
module caliptra_imem_stream_loader #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned ADDR_W   = 13,
  parameter int unsigned DEPTH    = 8192,
  parameter logic [7:0]  PAD_BYTE = 8'h00
) (
  input  logic              core_clk,
  input  logic              cptra_rst,
  input  logic              load_start,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              ext_imem_we,
  output logic [ADDR_W-1:0] ext_imem_addr,
  output logic [DATA_W-1:0] ext_imem_wdata,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_written,
  output logic              dut_rst_b
);

  localparam int unsigned      LANES     = DATA_W / 8;
  localparam int unsigned      IDX_W     = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(LANES - 1);
  localparam logic [ADDR_W:0]  DEPTH_W   = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_PAD   = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    byte_idx_q, byte_idx_d;
  logic [ADDR_W:0]     word_ptr_q, word_ptr_d;
  logic [DATA_W-1:0]   pack_q, pack_d;
  logic                last_q, last_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                rst_b_q, rst_b_d;
  logic                accept;

  assign s_ready = (state_q == S_FILL);
  assign accept  = s_valid & s_ready;

  // Next-state, packing and registered-output decode.
  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    word_ptr_d = word_ptr_q;
    pack_d     = pack_q;
    last_d     = last_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (load_start) begin
          state_d    = S_FILL;
          byte_idx_d = '0;
          word_ptr_d = '0;
          pack_d     = '0;
          last_d     = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      S_FILL: begin
        if (accept) begin
          pack_d[{byte_idx_q, 3'b000} +: 8] = s_data;
          last_d = s_last;
          // A byte arriving with IMEM already full is an oversized image.
          if (word_ptr_q == DEPTH_W) begin
            state_d = S_ERR;
          end else if (byte_idx_q == LAST_LANE) begin
            state_d    = S_WRITE;
            byte_idx_d = '0;
          end else if (s_last) begin
            state_d    = S_PAD;
            byte_idx_d = byte_idx_q + IDX_W'(1);
          end else begin
            byte_idx_d = byte_idx_q + IDX_W'(1);
          end
        end else begin
          state_d = S_FILL;
        end
      end
      S_PAD: begin
        for (int i = 0; i < int'(LANES); i++) begin
          if (i >= int'(byte_idx_q)) begin
            pack_d[8*i +: 8] = PAD_BYTE;
          end else begin
            pack_d[8*i +: 8] = pack_q[8*i +: 8];
          end
        end
        byte_idx_d = '0;
        state_d    = S_WRITE;
      end
      S_WRITE: begin
        word_ptr_d = word_ptr_q + (ADDR_W + 1)'(1);
        pack_d     = '0;
        if (last_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_FILL;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    we_d    = (state_d == S_WRITE);
    addr_d  = we_d ? word_ptr_q[ADDR_W-1:0] : addr_q;
    wdata_d = we_d ? pack_d : wdata_q;
    busy_d  = (state_d == S_FILL) || (state_d == S_PAD) || (state_d == S_WRITE);
    done_d  = (state_d == S_DONE);
    err_d   = (state_d == S_ERR);
    rst_b_d = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge core_clk) begin
    if (cptra_rst) begin
      state_q    <= S_IDLE;
      byte_idx_q <= '0;
      word_ptr_q <= '0;
      pack_q     <= '0;
      last_q     <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rst_b_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      word_ptr_q <= word_ptr_d;
      pack_q     <= pack_d;
      last_q     <= last_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rst_b_q    <= rst_b_d;
    end
  end

  assign ext_imem_we    = we_q;
  assign ext_imem_addr  = addr_q;
  assign ext_imem_wdata = wdata_q;
  assign load_busy      = busy_q;
  assign load_done      = done_q;
  assign load_err       = err_q;
  assign words_written  = word_ptr_q;
  assign dut_rst_b      = rst_b_q;

endmodule

// File: tb/tb_caliptra_imem_stream_loader.sv
// Directed bench for caliptra_imem_stream_loader: default build plus a DEPTH=4 build
// for the overflow case.
module tb_caliptra_imem_stream_loader;

  logic        core_clk = 1'b0;
  logic        cptra_rst, load_start, load_start4;
  logic        s_valid, s_valid4, s_last;
  logic [7:0]  s_data;

  logic        s_ready, ext_imem_we, load_busy, load_done, load_err, dut_rst_b;
  logic [12:0] ext_imem_addr;
  logic [63:0] ext_imem_wdata;
  logic [13:0] words_written;

  logic        s_ready4, ext_imem_we4, load_busy4, load_done4, load_err4, dut_rst_b4;
  logic [12:0] ext_imem_addr4;
  logic [63:0] ext_imem_wdata4;
  logic [13:0] words_written4;

  int checks = 0;
  int errors = 0;
  int rdy_viol = 0;
  logic [12:0] wa_q[$];
  logic [63:0] wd_q[$];
  logic [12:0] wa4_q[$];
  logic [63:0] wd4_q[$];

  always #5 core_clk = ~core_clk;

  caliptra_imem_stream_loader dut (
    .core_clk(core_clk), .cptra_rst(cptra_rst), .load_start(load_start),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .ext_imem_we(ext_imem_we), .ext_imem_addr(ext_imem_addr), .ext_imem_wdata(ext_imem_wdata),
    .load_busy(load_busy), .load_done(load_done), .load_err(load_err),
    .words_written(words_written), .dut_rst_b(dut_rst_b)
  );

  caliptra_imem_stream_loader #(.DEPTH(4)) dut4 (
    .core_clk(core_clk), .cptra_rst(cptra_rst), .load_start(load_start4),
    .s_valid(s_valid4), .s_data(s_data), .s_last(s_last), .s_ready(s_ready4),
    .ext_imem_we(ext_imem_we4), .ext_imem_addr(ext_imem_addr4), .ext_imem_wdata(ext_imem_wdata4),
    .load_busy(load_busy4), .load_done(load_done4), .load_err(load_err4),
    .words_written(words_written4), .dut_rst_b(dut_rst_b4)
  );

  // Write log and ready/write overlap monitor, sampled on the inactive edge.
  always @(negedge core_clk) begin
    if (ext_imem_we) begin
      wa_q.push_back(ext_imem_addr);
      wd_q.push_back(ext_imem_wdata);
    end
    if (ext_imem_we && s_ready) rdy_viol++;
    if (ext_imem_we4) begin
      wa4_q.push_back(ext_imem_addr4);
      wd4_q.push_back(ext_imem_wdata4);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the negedge following the accepting posedge.
  task automatic send_byte(input bit sel, input logic [7:0] d, input logic l);
    int n;
    n = 0;
    s_data = d;
    s_last = l;
    if (sel) s_valid4 = 1'b1; else s_valid = 1'b1;
    while (!(sel ? s_ready4 : s_ready) && n < 40) begin
      @(negedge core_clk);
      n++;
    end
    checks++;
    if (!(sel ? s_ready4 : s_ready)) begin
      errors++;
      $display("FAIL send_byte: s_ready=0 after %0d cycles for byte %02h, required 1", n, d);
    end
    @(negedge core_clk);
    s_valid  = 1'b0;
    s_valid4 = 1'b0;
    s_last   = 1'b0;
  endtask

  task automatic pulse_start(input bit sel);
    if (sel) load_start4 = 1'b1; else load_start = 1'b1;
    @(negedge core_clk);
    load_start  = 1'b0;
    load_start4 = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!load_done && n < 20) begin
      @(negedge core_clk);
      n++;
    end
  endtask

  task automatic settle();
    @(negedge core_clk);
    #1;
  endtask

  task automatic test_reset();
    cptra_rst = 1'b1; load_start = 1'b0; load_start4 = 1'b0;
    s_valid = 1'b0; s_valid4 = 1'b0; s_last = 1'b0; s_data = 8'h00;
    repeat (3) @(negedge core_clk);
    cptra_rst = 1'b0;
    @(negedge core_clk);
    checks++;
    if ({s_ready, ext_imem_we, load_busy, load_done, load_err, dut_rst_b} !== 6'b000000) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 000000",
               {s_ready, ext_imem_we, load_busy, load_done, load_err, dut_rst_b});
    end
    checks++;
    if (ext_imem_addr !== 13'd0 || ext_imem_wdata !== 64'd0 || words_written !== 14'd0) begin
      errors++;
      $display("FAIL reset_values: addr=%0h wdata=%0h ww=%0d, required 0/0/0",
               ext_imem_addr, ext_imem_wdata, words_written);
    end
    checks++;
    if ({load_err4, dut_rst_b4, load_busy4} !== 3'b000) begin
      errors++;
      $display("FAIL reset_dut4: got %b, required 000", {load_err4, dut_rst_b4, load_busy4});
    end
  endtask

  task automatic test_full_words();
    int n;
    wa_q.delete(); wd_q.delete();
    pulse_start(1'b0);
    checks++;
    if (load_busy !== 1'b1 || dut_rst_b !== 1'b0) begin
      errors++;
      $display("FAIL full_start: busy=%b rst_b=%b, required 1/0", load_busy, dut_rst_b);
    end
    for (int i = 0; i < 16; i++) send_byte(1'b0, 8'(i), i == 15);
    wait_done(n);
    checks++;
    if (n !== 1) begin
      errors++;
      $display("FAIL full_latency: load_done after %0d negedges, required 1", n);
    end
    settle();
    checks++;
    if (wa_q.size() !== 2) begin
      errors++;
      $display("FAIL full_count: %0d writes, required 2", wa_q.size());
    end else begin
      checks++;
      if (wa_q[0] !== 13'd0 || wd_q[0] !== 64'h0706050403020100) begin
        errors++;
        $display("FAIL full_w0: addr=%0h data=%016h, required 0/0706050403020100", wa_q[0], wd_q[0]);
      end
      checks++;
      if (wa_q[1] !== 13'd1 || wd_q[1] !== 64'h0F0E0D0C0B0A0908) begin
        errors++;
        $display("FAIL full_w1: addr=%0h data=%016h, required 1/0F0E0D0C0B0A0908", wa_q[1], wd_q[1]);
      end
    end
    checks++;
    if (words_written !== 14'd2 || load_done !== 1'b1 || dut_rst_b !== 1'b1 || ext_imem_we !== 1'b0) begin
      errors++;
      $display("FAIL full_done: ww=%0d done=%b rst_b=%b we=%b, required 2/1/1/0",
               words_written, load_done, dut_rst_b, ext_imem_we);
    end
  endtask

  task automatic test_padded_word();
    int n;
    wa_q.delete(); wd_q.delete();
    pulse_start(1'b0);
    checks++;
    if (dut_rst_b !== 1'b0 || words_written !== 14'd0 || load_done !== 1'b0) begin
      errors++;
      $display("FAIL restart_from_done: rst_b=%b ww=%0d done=%b, required 0/0/0",
               dut_rst_b, words_written, load_done);
    end
    send_byte(1'b0, 8'hAA, 1'b0);
    send_byte(1'b0, 8'hBB, 1'b0);
    send_byte(1'b0, 8'hCC, 1'b1);
    checks++;
    if (s_ready !== 1'b0 || load_busy !== 1'b1 || ext_imem_we !== 1'b0) begin
      errors++;
      $display("FAIL pad_cycle: ready=%b busy=%b we=%b, required 0/1/0", s_ready, load_busy, ext_imem_we);
    end
    wait_done(n);
    checks++;
    if (n !== 2) begin
      errors++;
      $display("FAIL pad_latency: load_done after %0d negedges, required 2", n);
    end
    settle();
    checks++;
    if (wa_q.size() !== 1 || wa_q[0] !== 13'd0 || wd_q[0] !== 64'h0000000000CCBBAA) begin
      errors++;
      $display("FAIL pad_word: n=%0d addr=%0h data=%016h, required 1/0/0000000000CCBBAA",
               wa_q.size(), wa_q[0], wd_q[0]);
    end
  endtask

  task automatic test_random_valid();
    int n;
    logic [63:0] exp_w;
    wa_q.delete(); wd_q.delete();
    rdy_viol = 0;
    pulse_start(1'b0);
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 1) @(negedge core_clk);
      if (i == 5) pulse_start(1'b0);
      send_byte(1'b0, 8'h80 + 8'(i), i == 23);
    end
    wait_done(n);
    settle();
    checks++;
    if (wa_q.size() !== 3) begin
      errors++;
      $display("FAIL rand_count: %0d writes, required 3", wa_q.size());
    end else begin
      for (int w = 0; w < 3; w++) begin
        for (int k = 0; k < 8; k++) exp_w[8*k +: 8] = 8'h80 + 8'(8*w + k);
        checks++;
        if (wa_q[w] !== 13'(w) || wd_q[w] !== exp_w) begin
          errors++;
          $display("FAIL rand_w%0d: addr=%0h data=%016h, required %0h/%016h", w, wa_q[w], wd_q[w], w, exp_w);
        end
      end
    end
    checks++;
    if (rdy_viol !== 0 || words_written !== 14'd3 || load_done !== 1'b1) begin
      errors++;
      $display("FAIL rand_status: ready_during_write=%0d ww=%0d done=%b, required 0/3/1",
               rdy_viol, words_written, load_done);
    end
  endtask

  task automatic test_reset_mid_load();
    wa_q.delete(); wd_q.delete();
    pulse_start(1'b0);
    for (int i = 0; i < 13; i++) send_byte(1'b0, 8'h40 + 8'(i), 1'b0);
    cptra_rst = 1'b1;
    @(negedge core_clk);
    cptra_rst = 1'b0;
    checks++;
    if ({s_ready, ext_imem_we, load_busy, load_done, load_err, dut_rst_b} !== 6'b000000 ||
        ext_imem_addr !== 13'd0 || ext_imem_wdata !== 64'd0 || words_written !== 14'd0) begin
      errors++;
      $display("FAIL midrst_values: flags=%b addr=%0h wdata=%0h ww=%0d, required all 0",
               {s_ready, ext_imem_we, load_busy, load_done, load_err, dut_rst_b},
               ext_imem_addr, ext_imem_wdata, words_written);
    end
    repeat (4) @(negedge core_clk);
    settle();
    checks++;
    if (wa_q.size() !== 1 || wa_q[0] !== 13'd0 || wd_q[0] !== 64'h4746454443424140 || load_busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_writes: n=%0d addr=%0h data=%016h busy=%b, required 1/0/4746454443424140/0",
               wa_q.size(), wa_q[0], wd_q[0], load_busy);
    end
  endtask

  task automatic test_overflow();
    int held;
    logic [63:0] exp_w;
    wa4_q.delete(); wd4_q.delete();
    pulse_start(1'b1);
    for (int j = 0; j < 33; j++) send_byte(1'b1, 8'(j), 1'b0);
    checks++;
    if (load_err4 !== 1'b1 || dut_rst_b4 !== 1'b0 || load_busy4 !== 1'b0) begin
      errors++;
      $display("FAIL ovf_err: err=%b rst_b=%b busy=%b, required 1/0/0", load_err4, dut_rst_b4, load_busy4);
    end
    held = 0;
    s_data = 8'd33;
    s_valid4 = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge core_clk);
      if (s_ready4 === 1'b0 && load_err4 === 1'b1) held++;
    end
    s_valid4 = 1'b0;
    checks++;
    if (held !== 5) begin
      errors++;
      $display("FAIL ovf_sticky: err/not-ready held %0d of 5 cycles, required 5", held);
    end
    settle();
    checks++;
    if (wa4_q.size() !== 4) begin
      errors++;
      $display("FAIL ovf_count: %0d writes, required 4", wa4_q.size());
    end else begin
      for (int w = 0; w < 4; w++) begin
        for (int k = 0; k < 8; k++) exp_w[8*k +: 8] = 8'(8*w + k);
        checks++;
        if (wa4_q[w] !== 13'(w) || wd4_q[w] !== exp_w) begin
          errors++;
          $display("FAIL ovf_w%0d: addr=%0h data=%016h, required %0h/%016h", w, wa4_q[w], wd4_q[w], w, exp_w);
        end
      end
    end
    pulse_start(1'b1);
    checks++;
    if (load_err4 !== 1'b0 || load_busy4 !== 1'b1 || words_written4 !== 14'd0) begin
      errors++;
      $display("FAIL ovf_restart: err=%b busy=%b ww=%0d, required 0/1/0", load_err4, load_busy4, words_written4);
    end
  endtask

  initial begin
    @(negedge core_clk);
    test_reset();
    test_full_words();
    test_padded_word();
    test_random_valid();
    test_reset_mid_load();
    test_overflow();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/caliptra_imem_stream_loader.md
Name: caliptra_imem_stream_loader

Overview:
- Upstream feeder for the verilated top's external IMEM write port (ext_imem_we/addr/wdata).
- Accepts a byte stream from the C++ harness, packs bytes little-endian into 64-bit IMEM words and writes them sequentially from word address 0.
- Holds the Caliptra core reset asserted until a complete image has been written.

Parameters:
- DATA_W, 64, IMEM word width in bits; must be a multiple of 8.
- ADDR_W, 13, IMEM word-address width.
- DEPTH, 8192, IMEM depth in words; must be ≤ 2**ADDR_W.
- PAD_BYTE, 8'h00, fill value for a partial final word.

Ports:
- core_clk  input  1  clock.
- cptra_rst  input  1  synchronous active-high reset.
- load_start  input  1  one-cycle pulse that begins a new image load.
- s_valid  input  1  byte-stream valid.
- s_data  input  8  byte-stream data.
- s_last  input  1  marks the final byte of the image; qualified by s_valid.
- s_ready  output  1  byte-stream ready.
- ext_imem_we  output  1  IMEM write strobe.
- ext_imem_addr  output  ADDR_W  IMEM word address.
- ext_imem_wdata  output  DATA_W  IMEM write data.
- load_busy  output  1  high in FILL, WRITE or PAD.
- load_done  output  1  high in DONE.
- load_err  output  1  high in ERR.
- words_written  output  ADDR_W+1  count of IMEM words written during the current load.
- dut_rst_b  output  1  active-low reset to caliptra_top; low except in DONE.

Behaviour:
- Interface: one clock, core_clk; reset is cptra_rst, synchronous and active-high. All outputs registered except s_ready, which is decoded from state.
- Reset values: state IDLE. s_ready, ext_imem_we, load_busy, load_done, load_err = 0; ext_imem_addr, ext_imem_wdata, words_written = 0; dut_rst_b = 0.
- Byte accept: s_valid & s_ready.
- Byte lane: k-th accepted byte of a word goes to bits [8k+7:8k]; k counts 0..DATA_W/8-1.
- IDLE:
  - s_ready = 0.
  - load_start -> FILL; clears byte index, word pointer, words_written and pack register.
- FILL:
  - s_ready = 1.
  - Accept with k = last lane -> WRITE, whether or not s_last is set.
  - Accept with s_last and k < last lane -> PAD.
  - If word pointer == DEPTH and a byte is accepted -> ERR; no IMEM write occurs.
- PAD:
  - s_ready = 0.
  - Fills all remaining lanes with PAD_BYTE in one cycle, then -> WRITE.
- WRITE:
  - s_ready = 0.
  - ext_imem_we = 1 for exactly one cycle, with ext_imem_addr = word pointer and ext_imem_wdata = packed word.
  - Word pointer and words_written increment by 1.
  - -> DONE if the word held the s_last byte, else -> FILL with k = 0.
- Throughput and latency: one full word takes 9 cycles (8 accepts + 1 write). The last-byte accept to load_done rising is 2 cycles for a full word and 3 cycles for a padded word.
- DONE:
  - load_done = 1 and dut_rst_b = 1.
  - load_start -> FILL; dut_rst_b falls on the next cycle.
- ERR:
  - Sticky: load_err = 1, dut_rst_b = 0.
  - Only load_start or cptra_rst exits ERR.
- load_start is ignored while load_busy = 1.
- s_valid with s_ready = 0 is held by the source; the loader drops no bytes.
- ext_imem_we is 0 in every state except WRITE.
- ext_imem_addr and ext_imem_wdata hold their last values when ext_imem_we = 0.
- cptra_rst mid-load:
  - Next cycle is IDLE with all reset values.
  - A word not yet in WRITE is never written.
  - dut_rst_b = 0.

Test Plan:
- Reset, then load_start, then stream bytes 0x00..0x0F with s_last on 0x0F -> two writes: addr 0 = 64'h0706050403020100, addr 1 = 64'h0F0E0D0C0B0A0908. words_written = 2, load_done = 1, dut_rst_b = 1.
- Stream 3 bytes 0xAA, 0xBB, 0xCC with s_last on 0xCC -> one write: addr 0 = 64'h0000000000CCBBAA. load_done rises 3 cycles after the last accept.
- s_valid toggled 50% random over 24 bytes -> 3 writes with correct data; s_ready = 0 during each PAD/WRITE cycle; no byte lost or duplicated.
- DEPTH = 4 build, stream 40 bytes -> 4 writes at addr 0..3, then load_err = 1 on the 33rd byte, no 5th write, dut_rst_b = 0.
- cptra_rst asserted after 5 bytes of a second word -> only the first word is written, state IDLE, all outputs at reset values.
- load_start pulsed mid-FILL is ignored. load_start pulsed in DONE -> dut_rst_b = 0 next cycle, a fresh load starts at addr 0, words_written = 0.
